// File: rtl/led_matrix_scan_driver.sv
// Double-buffered 8x8 RGB row-scan driver with anti-ghost blanking and global PWM brightness.
// Optional build macro LED_GAMMA_EN squares the latched brightness (bits [15:8] of bri*bri).
module led_matrix_scan_driver #(
  parameter int ROW_DIV   = 6250,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [23:0] wr_data,
  input  logic        swap_req,
  input  logic [7:0]  brightness,
  output logic        swap_pending,
  output logic        swap_ack,
  output logic        frame_start,
  output logic [7:0]  row,
  output logic [23:0] col_rgb
);

  localparam logic [15:0] LAST_CNT  = 16'(ROW_DIV - 1);
  localparam logic [15:0] BLANK_CNT = 16'(BLANK_CYC);

  logic [15:0] dcnt;
  logic [2:0]  ridx;
  logic [7:0]  bri_q;
  logic        sel;          // 0: buffer A is front, 1: buffer B is front
  logic [23:0] buf_a [8];
  logic [23:0] buf_b [8];

  logic        active;
  logic        on;
  logic        boundary;
  logic [23:0] front_row;

  function automatic logic [7:0] eff_bri(input logic [7:0] b);
`ifdef LED_GAMMA_EN
    logic [15:0] prod;
    prod = {8'd0, b} * {8'd0, b};
    return prod[15:8];
`else
    return b;
`endif
  endfunction

  always_comb begin
    active    = (dcnt >= BLANK_CNT);
    on        = active && (dcnt[7:0] < eff_bri(bri_q));
    boundary  = (dcnt == LAST_CNT) && (ridx == 3'd7);
    front_row = sel ? buf_b[ridx] : buf_a[ridx];
  end

  // Scan counters, swap arbitration and registered pin drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt         <= '0;
      ridx         <= '0;
      bri_q        <= '0;
      sel          <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
      row          <= '0;
      col_rgb      <= '0;
    end else begin
      if (dcnt == LAST_CNT) begin
        dcnt <= '0;
        ridx <= ridx + 3'd1;
      end else begin
        dcnt <= dcnt + 16'd1;
      end

      if (dcnt == 16'd0)
        bri_q <= brightness;

      // A request landing in the boundary cycle with nothing pending waits one frame.
      if (boundary && swap_pending) begin
        sel          <= ~sel;
        swap_pending <= 1'b0;
        swap_ack     <= 1'b1;
      end else begin
        swap_ack <= 1'b0;
        if (swap_req)
          swap_pending <= 1'b1;
      end

      frame_start <= boundary;
      row         <= active ? (8'd1 << ridx) : 8'd0;
      col_rgb     <= on ? front_row : 24'd0;
    end
  end

  // Writes go to whichever buffer is back at the start of the cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else if (wr_en) begin
      if (sel)
        buf_a[wr_row] <= wr_data;
      else
        buf_b[wr_row] <= wr_data;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver with ROW_DIV=512, BLANK_CYC=16 (4096-cycle frame).
`timescale 1ns/1ps
module tb_led_matrix_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = 3'd0;
  logic [23:0] wr_data = 24'd0;
  logic        swap_req = 1'b0;
  logic [7:0]  brightness = 8'd0;
  logic        swap_pending;
  logic        swap_ack;
  logic        frame_start;
  logic [7:0]  row;
  logic [23:0] col_rgb;

`ifdef LED_GAMMA_EN
  localparam int FULL_ON = 492;  // eff 254: dcnt[7:0] 254,255 off in both halves
  localparam int HALF_ON = 112;  // eff 64: 16..63 + 256..319
`else
  localparam int FULL_ON = 494;  // eff 255: dcnt 255 and 511 off
  localparam int HALF_ON = 240;  // eff 128: 16..127 + 256..383
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_total = 0;
  int fs_total = 0;

  led_matrix_scan_driver #(.ROW_DIV(512), .BLANK_CYC(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .brightness(brightness), .swap_pending(swap_pending),
    .swap_ack(swap_ack), .frame_start(frame_start), .row(row), .col_rgb(col_rgb)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // After step, cyc=n means outputs reflect counter state n-1 and the next edge samples state n.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (swap_ack === 1'b1) ack_total++;
    if (frame_start === 1'b1) fs_total++;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic measure_dwell(input int base, input logic [23:0] data, input int chg_at,
                               input logic [7:0] chg_bri, output int on_cnt, output int bad_cnt);
    int r;
    logic [7:0] er;
    on_cnt = 0;
    bad_cnt = 0;
    r = (base / 512) % 8;
    go_to(base);
    for (int k = 0; k < 512; k++) begin
      if (k == chg_at) brightness = chg_bri;
      step();
      er = (k >= 16) ? (8'd1 << r) : 8'd0;
      if (row !== er) bad_cnt++;
      if (col_rgb !== 24'd0) begin
        if (k < 16 || col_rgb !== data) bad_cnt++;
        else on_cnt++;
      end
    end
  endtask

  task automatic measure_frame(input int base, input logic [23:0] data,
                               output int on_cnt, output int bad_cnt);
    int o, b;
    on_cnt = 0;
    bad_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      measure_dwell(base + r * 512, data, -1, 8'd0, o, b);
      on_cnt += o;
      bad_cnt += b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #12;
    checks++; if (row !== 8'd0) begin failures++; $display("FAIL reset_row: got %h expected 00", row); end
    checks++; if (col_rgb !== 24'd0) begin failures++; $display("FAIL reset_col: got %h expected 000000", col_rgb); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", swap_pending); end
    checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", swap_ack); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_swap();
    int on_c, bad_c;
    brightness = 8'd255;
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 24'hFFFFFF;
    step();
    wr_en = 1'b0;
    go_to(612);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin failures++; $display("FAIL swap_pending_set: got %b expected 1", swap_pending); end
    measure_dwell(1536, 24'hFFFFFF, -1, 8'd0, on_c, bad_c);
    checks++; if (on_c !== 0) begin failures++; $display("FAIL front_untouched: got %0d lit cycles expected 0", on_c); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL front_untouched_bad: got %0d expected 0", bad_c); end
    go_to(4095);
    checks++; if (swap_pending !== 1'b1 || swap_ack !== 1'b0) begin failures++; $display("FAIL pending_hold: got pend=%b ack=%b expected 1/0", swap_pending, swap_ack); end
    step();
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL swap_ack: got %b expected 1", swap_ack); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL swap_fs: got %b expected 1", frame_start); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL swap_clear: got %b expected 0", swap_pending); end
    step();
    checks++; if (swap_ack !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("FAIL ack_single: got ack=%b fs=%b expected 0/0", swap_ack, frame_start); end
    measure_dwell(4096 + 1536, 24'hFFFFFF, -1, 8'd0, on_c, bad_c);
    checks++; if (on_c !== FULL_ON) begin failures++; $display("FAIL full_duty: got %0d expected %0d", on_c, FULL_ON); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL full_duty_bad: got %0d expected 0", bad_c); end
  endtask

  task automatic test_zero_brightness();
    int on_c, bad_c, f0;
    for (int r = 0; r < 8; r++) begin
      wr_en = 1'b1; wr_row = 3'(r); wr_data = 24'hFFFFFF;
      step();
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    brightness = 8'd0;
    go_to(8192);
    f0 = fs_total;
    measure_frame(8192, 24'hFFFFFF, on_c, bad_c);
    checks++; if (on_c !== 0) begin failures++; $display("FAIL zero_bri_on: got %0d expected 0", on_c); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL zero_bri_bad: got %0d expected 0", bad_c); end
    checks++; if (fs_total - f0 !== 1) begin failures++; $display("FAIL frame_rate: got %0d expected 1", fs_total - f0); end
  endtask

  task automatic test_half_brightness();
    int on_c, bad_c;
    brightness = 8'd128;
    measure_dwell(12288, 24'hFFFFFF, -1, 8'd0, on_c, bad_c);
    checks++; if (on_c !== HALF_ON) begin failures++; $display("FAIL half_duty: got %0d expected %0d", on_c, HALF_ON); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL half_duty_bad: got %0d expected 0", bad_c); end
  endtask

  task automatic test_bri_midrow();
    int on_c, bad_c;
    brightness = 8'd255;
    measure_dwell(12800, 24'hFFFFFF, 300, 8'd0, on_c, bad_c);
    checks++; if (on_c !== FULL_ON) begin failures++; $display("FAIL midrow_hold: got %0d expected %0d", on_c, FULL_ON); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL midrow_hold_bad: got %0d expected 0", bad_c); end
    measure_dwell(13312, 24'hFFFFFF, -1, 8'd0, on_c, bad_c);
    checks++; if (on_c !== 0) begin failures++; $display("FAIL midrow_next: got %0d expected 0", on_c); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL midrow_next_bad: got %0d expected 0", bad_c); end
  endtask

  task automatic test_multi_swap();
    int on_c, bad_c, a0;
    brightness = 8'd255;
    a0 = ack_total;
    go_to(13900); swap_req = 1'b1; step(); swap_req = 1'b0;
    go_to(14500); swap_req = 1'b1; step(); swap_req = 1'b0;
    go_to(15000); swap_req = 1'b1; step(); swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin failures++; $display("FAIL multi_pending: got %b expected 1", swap_pending); end
    go_to(16383);
    wr_en = 1'b1; wr_row = 3'd0; wr_data = 24'h000007;
    step();
    wr_en = 1'b0;
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL multi_ack: got %b expected 1", swap_ack); end
    measure_dwell(16384, 24'h000007, -1, 8'd0, on_c, bad_c);
    checks++; if (on_c !== FULL_ON) begin failures++; $display("FAIL swap_cycle_write: got %0d expected %0d", on_c, FULL_ON); end
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL swap_cycle_write_bad: got %0d expected 0", bad_c); end
    go_to(20480);
    checks++; if (ack_total - a0 !== 1) begin failures++; $display("FAIL merged_acks: got %0d expected 1", ack_total - a0); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL merged_pending: got %b expected 0", swap_pending); end
  endtask

  task automatic test_async_reset();
    int on_c, bad_c, a0, f0;
    go_to(20480 + 1536 + 200);
    checks++; if (col_rgb !== 24'hFFFFFF) begin failures++; $display("FAIL pre_reset_col: got %h expected ffffff", col_rgb); end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin failures++; $display("FAIL pre_reset_pending: got %b expected 1", swap_pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (row !== 8'd0) begin failures++; $display("FAIL async_row: got %h expected 00", row); end
    checks++; if (col_rgb !== 24'd0) begin failures++; $display("FAIL async_col: got %h expected 000000", col_rgb); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL async_pending: got %b expected 0", swap_pending); end
    #20;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    a0 = ack_total;
    f0 = fs_total;
    measure_frame(0, 24'h000000, on_c, bad_c);
    checks++; if (bad_c !== 0) begin failures++; $display("FAIL cleared_frame: got %0d bad cycles expected 0", bad_c); end
    checks++; if (ack_total - a0 !== 0) begin failures++; $display("FAIL dropped_swap: got %0d acks expected 0", ack_total - a0); end
    checks++; if (fs_total - f0 !== 1) begin failures++; $display("FAIL post_reset_fs: got %0d expected 1", fs_total - f0); end
  endtask

  initial begin
    test_reset();
    test_swap();
    test_zero_brightness();
    test_half_brightness();
    test_bri_midrow();
    test_multi_swap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
